// File: rtl/mem_load_align_pkg.sv
// Shared memory-access constants: load opcodes, reset pc and the MEM stage
// register layout. The store-alignment logic imports the same opcode set.
package mem_load_align_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LWL = 6'b100010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LWR = 6'b100110;

   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   // Fields latched from EXE into MEM
   typedef struct packed {
      logic [31:0] inst;
      logic [4:0]  dest;
      logic [31:0] value;
      logic [31:0] rt;
      logic [31:0] pc;
   } mem_stage_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB)  || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW)  || (op == OP_LWL) ||
             (op == OP_LWR);
   endfunction

endpackage

// File: rtl/mem_load_align_load_extract.sv
// Load data extraction and LWL/LWR merge. Purely combinational; the caller
// decides whether the opcode is a load at all.
module load_extract
   import mem_load_align_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [1:0]  a,
   input  logic [31:0] word,
   input  logic [31:0] rt,
   output logic [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte / halfword lanes selected by the low address bits
   always_comb begin
      w_byte = word[7:0];
      case (a)
         2'd0: w_byte = word[7:0];
         2'd1: w_byte = word[15:8];
         2'd2: w_byte = word[23:16];
         2'd3: w_byte = word[31:24];
         default: w_byte = word[7:0];
      endcase
      w_half = a[1] ? word[31:16] : word[15:0];
   end

   // Extension and unaligned-word merge with the old rt value
   always_comb begin
      result = word;
      case (opcode)
         OP_LB:  result = {{24{w_byte[7]}}, w_byte};
         OP_LBU: result = {24'd0, w_byte};
         OP_LH:  result = {{16{w_half[15]}}, w_half};
         OP_LHU: result = {16'd0, w_half};
         OP_LW:  result = word;
         OP_LWL: begin
            case (a)
               2'd0: result = {word[7:0],  rt[23:0]};
               2'd1: result = {word[15:0], rt[15:0]};
               2'd2: result = {word[23:0], rt[7:0]};
               default: result = word;
            endcase
         end
         OP_LWR: begin
            case (a)
               2'd0: result = word;
               2'd1: result = {rt[31:24], word[31:8]};
               2'd2: result = {rt[31:16], word[31:16]};
               default: result = {rt[31:8], word[31:24]};
            endcase
         end
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_load_align.sv
// MEM pipeline stage: latches the EXE instruction, aligns SRAM load data and
// keeps the SRAM word in a hold buffer while WB back-pressures, since the
// SRAM only presents read data for one cycle.
module mem_load_align
   import mem_load_align_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        exe_valid,
   input  logic [31:0] exe_inst,
   input  logic [31:0] exe_pc,
   input  logic [4:0]  exe_dest,
   input  logic [31:0] exe_value,
   input  logic [31:0] exe_rt_value,
   input  logic [31:0] data_sram_rdata,
   input  logic        wb_allowin,
   output logic        mem_allowin,
   output logic        mem_valid,
   output logic [4:0]  mem_dest,
   output logic [31:0] mem_value,
   output logic [31:0] mem_pc,
   output logic        mem_rf_we
);

   mem_stage_t  r_stage;
   logic        r_valid;
   logic        r_hold_vld;
   logic [31:0] r_hold_word;
   logic [31:0] w_word;
   logic [31:0] w_load;
   logic        w_unused;

   assign mem_allowin = !r_valid || wb_allowin;

   // Stage register: advances whenever MEM can accept, holds during a stall
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_stage <= '{inst: '0, dest: '0, value: '0, rt: '0, pc: RESET_PC};
      end else if (mem_allowin) begin
         r_valid <= exe_valid;
         r_stage <= '{inst: exe_inst, dest: exe_dest, value: exe_value,
                      rt: exe_rt_value, pc: exe_pc};
      end
   end

   // Hold buffer: grab the SRAM word on the first stalled cycle only
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hold_vld  <= 1'b0;
         r_hold_word <= '0;
      end else if (mem_allowin) begin
         r_hold_vld  <= 1'b0;
      end else if (!r_hold_vld) begin
         r_hold_vld  <= 1'b1;
         r_hold_word <= data_sram_rdata;
      end
   end

   assign w_word = r_hold_vld ? r_hold_word : data_sram_rdata;

   load_extract u_extract (
      .opcode (r_stage.inst[31:26]),
      .a      (r_stage.value[1:0]),
      .word   (w_word),
      .rt     (r_stage.rt),
      .result (w_load)
   );

   assign mem_valid = r_valid;
   assign mem_dest  = r_stage.dest;
   assign mem_pc    = r_stage.pc;
   assign mem_value = is_load(r_stage.inst[31:26]) ? w_load : r_stage.value;
   assign mem_rf_we = r_valid && (r_stage.dest != 5'd0);

   // Only the opcode field of the latched instruction matters here
   assign w_unused = &{1'b0, r_stage.inst[25:0]};

endmodule

// File: tb/tb_mem_load_align.sv
// Bench for mem_load_align: directed cases then a randomized back-pressure run
// checked against a word-arithmetic load model.
module tb_mem_load_align;

   localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LWL = 6'b100010,
                          LW = 6'b100011, LBU = 6'b100100, LHU = 6'b100101,
                          LWR = 6'b100110, ADDU = 6'b000000, ADDIU = 6'b001001;

   logic        clk = 1'b0;
   logic        resetn;
   logic        exe_valid;
   logic [31:0] exe_inst, exe_pc, exe_value, exe_rt_value, data_sram_rdata;
   logic [4:0]  exe_dest;
   logic        wb_allowin;
   logic        mem_allowin, mem_valid, mem_rf_we;
   logic [4:0]  mem_dest;
   logic [31:0] mem_value, mem_pc;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_load_align dut (
      .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_inst(exe_inst),
      .exe_pc(exe_pc), .exe_dest(exe_dest), .exe_value(exe_value),
      .exe_rt_value(exe_rt_value), .data_sram_rdata(data_sram_rdata),
      .wb_allowin(wb_allowin), .mem_allowin(mem_allowin), .mem_valid(mem_valid),
      .mem_dest(mem_dest), .mem_value(mem_value), .mem_pc(mem_pc),
      .mem_rf_we(mem_rf_we)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
         $error("check %s mismatched", tag);
      end
   endtask

   // Reference: loads described as shifts/masks over the 32-bit word
   function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] value,
                                              input logic [31:0] rt, input logic [31:0] m);
      int unsigned a = value[1:0];
      logic [63:0] sh, msk;
      logic [31:0] b, h;
      b = (m >> (8 * a)) & 32'hFF;
      h = (m >> (16 * (a / 2))) & 32'hFFFF;
      case (op)
         LB:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
         LBU: return b;
         LH:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
         LHU: return h;
         LW:  return m;
         LWL: begin
            sh  = {32'd0, m} << (8 * (3 - a));
            msk = (64'd1 << (8 * (3 - a))) - 64'd1;
            return sh[31:0] | (rt & msk[31:0]);
         end
         LWR: begin
            msk = 64'hFFFFFFFF >> (8 * a);
            return (m >> (8 * a)) | (rt & ~msk[31:0]);
         end
         default: return value;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] d,
                        input logic [31:0] val, input logic [31:0] rt, input logic [31:0] pc);
      exe_valid = v; exe_inst = {op, 26'h15A5A5A}; exe_dest = d;
      exe_value = val; exe_rt_value = rt; exe_pc = pc;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // One stall-free load: present in EXE, supply rdata next cycle, check result
   task automatic one_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
      wb_allowin = 1'b1;
      drive(1'b1, op, 5'd9, addr, rt, 32'h00400100);
      tick;
      drive(1'b0, ADDU, 5'd0, 32'd0, 32'd0, 32'd0);
      data_sram_rdata = rd;
      #2;
      check(tag, mem_value, exp);
      check({tag, "_we"}, {31'd0, mem_rf_we}, 32'd1);
   endtask

   logic        m_valid, m_fresh;
   logic [5:0]  m_op;
   logic [4:0]  m_dest;
   logic [31:0] m_value, m_rt, m_pc, m_word;
   logic [5:0]  ops [9];

   initial begin
      ops = '{LB, LBU, LH, LHU, LW, LWL, LWR, ADDU, ADDIU};
      resetn = 1'b0; wb_allowin = 1'b1; data_sram_rdata = 32'h0;
      drive(1'b0, ADDU, 5'd0, 32'd0, 32'd0, 32'd0);
      tick; tick;
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_pc", mem_pc, 32'hbfc00000);
      check("rst_dest", {27'd0, mem_dest}, 32'd0);
      check("rst_we", {31'd0, mem_rf_we}, 32'd0);
      check("rst_allowin", {31'd0, mem_allowin}, 32'd1);
      resetn = 1'b1;
      tick;

      one_load("lb",  LB,  32'h10000002, 32'h0, 32'h12F45678, 32'hFFFFFFF4);
      one_load("lbu", LBU, 32'h10000002, 32'h0, 32'h12F45678, 32'h000000F4);
      one_load("lh",  LH,  32'h10000002, 32'h0, 32'h80017FFF, 32'hFFFF8001);
      one_load("lhu", LHU, 32'h10000000, 32'h0, 32'h80017FFF, 32'h00007FFF);
      one_load("lwl", LWL, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344);
      one_load("lwr", LWR, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC);
      one_load("lwl3", LWL, 32'h10000003, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
      one_load("lwr0", LWR, 32'h10000000, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
      check("pc_lat", mem_pc, 32'h00400100);

      // LW stalled three cycles; SRAM word changes after the first
      wb_allowin = 1'b1;
      drive(1'b1, LW, 5'd3, 32'h10000000, 32'h0, 32'h00400200);
      tick;
      wb_allowin = 1'b0;
      data_sram_rdata = 32'h12345678;
      drive(1'b1, ADDU, 5'd0, 32'h00000005, 32'h0, 32'h00400204);
      #2;
      check("stall1_val", mem_value, 32'h12345678);
      check("stall1_allow", {31'd0, mem_allowin}, 32'd0);
      for (int c = 2; c <= 3; c++) begin
         tick;
         data_sram_rdata = 32'hDEADBEEF;
         #2;
         check($sformatf("stall%0d_val", c), mem_value, 32'h12345678);
         check($sformatf("stall%0d_allow", c), {31'd0, mem_allowin}, 32'd0);
         check($sformatf("stall%0d_pc", c), mem_pc, 32'h00400200);
         check($sformatf("stall%0d_hold", c), {31'd0, dut.r_hold_vld}, 32'd1);
      end
      tick;
      wb_allowin = 1'b1;
      #2;
      check("stall_rel_val", mem_value, 32'h12345678);
      check("stall_rel_allow", {31'd0, mem_allowin}, 32'd1);
      tick;
      drive(1'b0, ADDU, 5'd7, 32'h0, 32'h0, 32'h0);
      #2;
      check("addu_val", mem_value, 32'h00000005);
      check("addu_we", {31'd0, mem_rf_we}, 32'd0);
      check("addu_pc", mem_pc, 32'h00400204);
      check("addu_hold", {31'd0, dut.r_hold_vld}, 32'd0);
      tick;
      check("bubble_valid", {31'd0, mem_valid}, 32'd0);
      check("bubble_we", {31'd0, mem_rf_we}, 32'd0);

      // Reset while a LW is stalled
      drive(1'b1, LW, 5'd4, 32'h10000000, 32'h0, 32'h00400300);
      tick;
      wb_allowin = 1'b0;
      data_sram_rdata = 32'hCAFEF00D;
      drive(1'b0, ADDU, 5'd0, 32'h0, 32'h0, 32'h0);
      tick; tick;
      resetn = 1'b0;
      tick;
      #2;
      check("rstst_valid", {31'd0, mem_valid}, 32'd0);
      check("rstst_hold", {31'd0, dut.r_hold_vld}, 32'd0);
      check("rstst_pc", mem_pc, 32'hbfc00000);
      check("rstst_allow", {31'd0, mem_allowin}, 32'd1);
      resetn = 1'b1;
      wb_allowin = 1'b1;
      tick;

      // Randomized traffic with random WB back-pressure
      m_valid = 1'b0; m_fresh = 1'b0; m_op = ADDU; m_dest = 0;
      m_value = 0; m_rt = 0; m_pc = 0; m_word = 0;
      for (int i = 0; i < 400; i++) begin
         wb_allowin = ($urandom_range(0, 3) != 0);
         data_sram_rdata = (m_valid && m_fresh) ? m_word : $urandom();
         drive($urandom_range(0, 4) != 0, ops[$urandom_range(0, 8)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom(), $urandom(), $urandom());
         #3;
         check("rnd_allow", {31'd0, mem_allowin}, {31'd0, !m_valid || wb_allowin});
         check("rnd_valid", {31'd0, mem_valid}, {31'd0, m_valid});
         check("rnd_we", {31'd0, mem_rf_we}, {31'd0, m_valid && (m_dest != 0)});
         if (m_valid) begin
            check("rnd_val", mem_value, ref_result(m_op, m_value, m_rt, m_word));
            check("rnd_pc", mem_pc, m_pc);
            check("rnd_dest", {27'd0, mem_dest}, {27'd0, m_dest});
         end
         if (!m_valid || wb_allowin) begin
            m_valid = exe_valid; m_op = exe_inst[31:26]; m_dest = exe_dest;
            m_value = exe_value; m_rt = exe_rt_value; m_pc = exe_pc;
            m_word = $urandom(); m_fresh = 1'b1;
         end else begin
            m_fresh = 1'b0;
         end
         tick;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
